// File: rtl/i2c_master_ctrl_if.sv
// Bus bundle between the I2C write sequencer and its environment
// (requester, serial shift register and the SCL/SDA pads).
interface i2c_master_ctrl_if;
    logic       Start;
    logic [6:0] SlaveAddr;
    logic [7:0] WriteData;
    logic       ShiftOut;
    logic [7:0] DataIn;
    logic       Load;
    logic       Shift;
    logic       ShiftCLK;
    logic       SCL;
    logic       SdaDriveLow;
    logic       SdaIn;
    logic       Busy;
    logic       Done;
    logic       AckError;

    modport master (
        input  Start, SlaveAddr, WriteData, ShiftOut, SdaIn,
        output DataIn, Load, Shift, ShiftCLK, SCL, SdaDriveLow, Busy, Done, AckError
    );

    modport slave (
        output Start, SlaveAddr, WriteData, ShiftOut, SdaIn,
        input  DataIn, Load, Shift, ShiftCLK, SCL, SdaDriveLow, Busy, Done, AckError
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C write sequencer: START, address+W, ACK, data, ACK, STOP,
// feeding an external shift register and driving SCL / open-drain SDA.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic               CLK,
    input  logic               RESET,
    i2c_master_ctrl_if.master  bus
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK1  = 3'd3,
        DATA  = 3'd4,
        ACK2  = 3'd5,
        STOP  = 3'd6,
        DONE  = 3'd7
    } stateT;

    stateT         state;
    logic [QW-1:0] qCnt;
    logic [1:0]    phase;
    logic [2:0]    bitCnt;
    logic [7:0]    dataReg;
    logic          qTick;
    logic          bitEnd;

    // Quarter tick and end-of-bit strobe; timers never run in IDLE/DONE.
    always_comb begin
        qTick  = 1'b0;
        bitEnd = 1'b0;
        if ((state != IDLE) && (state != DONE)) begin
            qTick  = (qCnt == Q_LAST);
            bitEnd = (qCnt == Q_LAST) && (phase == 2'd3);
        end else begin
            qTick  = 1'b0;
            bitEnd = 1'b0;
        end
    end

    // Sequencer, timers and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state           <= IDLE;
            qCnt            <= '0;
            phase           <= 2'd0;
            bitCnt          <= 3'd0;
            dataReg         <= 8'h00;
            bus.DataIn      <= 8'h00;
            bus.Load        <= 1'b0;
            bus.Shift       <= 1'b0;
            bus.ShiftCLK    <= 1'b0;
            bus.SCL         <= 1'b1;
            bus.SdaDriveLow <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Done        <= 1'b0;
            bus.AckError    <= 1'b0;
        end else begin
            bus.Load     <= 1'b0;
            bus.Shift    <= 1'b0;
            bus.ShiftCLK <= 1'b0;
            bus.Busy     <= (state != IDLE);
            bus.Done     <= (state == DONE);

            // Line levels follow the current bit phase one clock later, so SDA
            // updates from the shift register always land while SCL is low.
            case (state)
                START: begin
                    bus.SCL         <= 1'b1;
                    bus.SdaDriveLow <= phase[1];
                end
                ADDR, DATA: begin
                    bus.SCL         <= phase[1];
                    bus.SdaDriveLow <= ~bus.ShiftOut;
                end
                ACK1, ACK2: begin
                    bus.SCL         <= phase[1];
                    bus.SdaDriveLow <= 1'b0;
                end
                STOP: begin
                    bus.SCL         <= phase[1];
                    bus.SdaDriveLow <= (phase != 2'd3);
                end
                default: begin
                    bus.SCL         <= 1'b1;
                    bus.SdaDriveLow <= 1'b0;
                end
            endcase

            if ((state == IDLE) || (state == DONE)) begin
                qCnt  <= '0;
                phase <= 2'd0;
            end else if (qTick) begin
                qCnt  <= '0;
                phase <= phase + 2'd1;
            end else begin
                qCnt  <= qCnt + QW'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        dataReg      <= bus.WriteData;
                        bus.DataIn   <= {bus.SlaveAddr, 1'b0};
                        bus.Load     <= 1'b1;
                        bus.AckError <= 1'b0;
                        state        <= START;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        bitCnt <= 3'd7;
                        state  <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    if (bitEnd) begin
                        bus.Shift    <= 1'b1;
                        bus.ShiftCLK <= 1'b1;
                        bitCnt       <= bitCnt - 3'd1;
                        if (bitCnt == 3'd0) begin
                            state <= (state == ADDR) ? ACK1 : ACK2;
                        end
                    end
                end
                ACK1, ACK2: begin
                    if (bitEnd) begin
                        if (bus.SdaIn) begin
                            bus.AckError <= 1'b1;
                            state        <= STOP;
                        end else if (state == ACK1) begin
                            bus.DataIn <= dataReg;
                            bus.Load   <= 1'b1;
                            bitCnt     <= 3'd7;
                            state      <= DATA;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Randomised self-checking bench for i2c_master_ctrl with a shift-register
// model and a transaction-level reference of the expected bus behaviour.
module tb_i2c_master_ctrl;

    localparam int DIV = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] srModel;

    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // External serial shift register the sequencer feeds.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET)         srModel <= 8'h00;
        else if (bus.Load)  srModel <= bus.DataIn;
        else if (bus.Shift) srModel <= {srModel[6:0], 1'b0};
    end

    assign bus.ShiftOut = srModel[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write transaction; abortRise != 0 resets the DUT at that SCL rise.
    task automatic runTxn(input logic [6:0] addr, input logic [7:0] data,
                          input logic nack1, input logic nack2,
                          input logic doRestart, input int abortRise);
        int k, rc, wait_n, loads, shifts, overlap, clkMis, dones, doneAt, firstLoad;
        int starts, stops;
        logic [7:0] loadVal [2];
        logic [7:0] addrByte, dataByte;
        logic prevScl, prevSda, busyK1, ackErrK, aborted;

        wait_n = 0;
        while (bus.Busy !== 1'b0 && wait_n < 200) begin
            @(negedge CLK);
            wait_n++;
        end
        check("idle_before_start", bus.Busy, 32'd0);

        bus.SlaveAddr = addr;
        bus.WriteData = data;
        bus.SdaIn     = 1'b0;
        bus.Start     = 1'b1;
        k = cyc + 1;
        rc = 0; loads = 0; shifts = 0; overlap = 0; clkMis = 0; dones = 0;
        doneAt = -1; firstLoad = -1; starts = 0; stops = 0;
        loadVal[0] = 8'h00; loadVal[1] = 8'h00;
        addrByte = 8'h00; dataByte = 8'h00;
        busyK1 = 1'b0; ackErrK = 1'b1; aborted = 1'b0;
        prevScl = bus.SCL; prevSda = bus.SdaDriveLow;

        for (int n = 0; n < 80 * DIV + 40; n++) begin
            @(negedge CLK);
            if (doRestart && cyc == k + 39) begin
                bus.Start     = 1'b1;
                bus.SlaveAddr = ~addr;
                bus.WriteData = ~data;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Load) begin
                if (loads < 2) loadVal[loads] = bus.DataIn;
                if (loads == 0) firstLoad = cyc;
                loads++;
            end
            if (bus.Shift) shifts++;
            if (bus.Shift !== bus.ShiftCLK) clkMis++;
            if (bus.Load && bus.Shift) overlap++;
            if (bus.Done) begin
                dones++;
                doneAt = cyc;
            end
            if (cyc == k)     ackErrK = bus.AckError;
            if (cyc == k + 1) busyK1  = bus.Busy;
            if (bus.SCL && !prevScl) begin
                rc++;
                if (rc <= 8) addrByte = {addrByte[6:0], ~bus.SdaDriveLow};
                else if (rc >= 10 && rc <= 17) dataByte = {dataByte[6:0], ~bus.SdaDriveLow};
            end
            if (bus.SCL && prevScl && bus.SdaDriveLow && !prevSda) starts++;
            if (bus.SCL && prevScl && !bus.SdaDriveLow && prevSda) stops++;
            prevScl = bus.SCL;
            prevSda = bus.SdaDriveLow;
            bus.SdaIn = (rc == 9) ? nack1 : ((rc == 18) ? nack2 : 1'b0);
            if (abortRise != 0 && rc == abortRise) begin
                aborted = 1'b1;
                break;
            end
            if (dones != 0 && bus.Busy == 1'b0) break;
        end

        if (aborted) begin
            RESET = 1'b0;
            #1;
            check("abort_scl", bus.SCL, 32'd1);
            check("abort_sda", bus.SdaDriveLow, 32'd0);
            check("abort_busy", bus.Busy, 32'd0);
            check("abort_ackerr", bus.AckError, 32'd0);
            check("abort_shift_load", {bus.Shift, bus.Load}, 32'd0);
            @(negedge CLK);
            @(negedge CLK);
            RESET = 1'b1;
            bus.SdaIn = 1'b0;
        end else begin
            check("done_cycle", doneAt, k + 1 + (nack1 ? 44 : 80) * DIV);
            check("done_count", dones, 32'd1);
            check("first_load_cycle", firstLoad, k);
            check("busy_after_start", busyK1, 32'd1);
            check("ackerr_cleared", ackErrK, 32'd0);
            check("load_count", loads, nack1 ? 32'd1 : 32'd2);
            check("load_addr", loadVal[0], {addr, 1'b0});
            if (!nack1) check("load_data", loadVal[1], data);
            check("shift_count", shifts, nack1 ? 32'd8 : 32'd16);
            check("shiftclk_equal", clkMis, 32'd0);
            check("load_shift_overlap", overlap, 32'd0);
            check("sda_addr_byte", addrByte, {addr, 1'b0});
            if (!nack1) check("sda_data_byte", dataByte, data);
            check("start_cond", starts, 32'd1);
            check("stop_cond", stops, 32'd1);
            check("ack_error", bus.AckError, 32'(nack1 | nack2));
        end
    endtask

    initial begin
        bus.Start     = 1'b0;
        bus.SlaveAddr = 7'h00;
        bus.WriteData = 8'h00;
        bus.SdaIn     = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("reset_scl", bus.SCL, 32'd1);
        check("reset_sda", bus.SdaDriveLow, 32'd0);
        check("reset_busy", bus.Busy, 32'd0);
        check("reset_done", bus.Done, 32'd0);
        check("reset_ackerr", bus.AckError, 32'd0);

        runTxn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
        runTxn(7'h50, 8'hA5, 1'b1, 1'b0, 1'b0, 0);
        runTxn(7'h50, 8'hA5, 1'b0, 1'b1, 1'b0, 0);
        runTxn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
        runTxn(7'h2B, 8'h3C, 1'b0, 1'b1, 1'b0, 0);
        runTxn(7'h11, 8'hF0, 1'b0, 1'b0, 1'b0, 14);
        runTxn(7'h11, 8'hF0, 1'b0, 1'b0, 1'b0, 0);
        for (int t = 0; t < 8; t++) begin
            runTxn(7'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Byte-level I2C write sequencer that sits directly upstream of the I2C serial shift register. It loads address and data bytes into the shift register and strobes shifts at bit boundaries. It consumes the register's serial output and generates SCL, SDA drive, START/STOP conditions and ACK checking. One transaction writes one data byte to a 7-bit slave address (R/W = 0).

Parameters:
CLK_DIV, 250, CLK cycles per quarter-bit period (minimum 1); SCL period = 4*CLK_DIV cycles.

Ports:
CLK  input  1  system clock, all state changes on rising edge
RESET  input  1  asynchronous, active-low reset
Start  input  1  request a transaction; sampled only when Busy = 0
SlaveAddr  input  7  target address, captured when Start is accepted
WriteData  input  8  data byte, captured when Start is accepted
ShiftOut  input  1  MSB/serial output from the shift register
DataIn  output  8  parallel load value to the shift register
Load  output  1  one-CLK pulse: shift register loads DataIn
Shift  output  1  one-CLK pulse: shift register advances one bit
ShiftCLK  output  1  one-CLK pulse, identical to Shift
SCL  output  1  I2C clock (push-pull)
SdaDriveLow  output  1  1 = pull SDA low; 0 = release (open-drain)
SdaIn  input  1  sampled SDA line, assumed synchronised
Busy  output  1  high from the cycle after Start is accepted through Done
Done  output  1  one-CLK pulse at the end of a transaction
AckError  output  1  sticky; set on NACK, cleared when the next Start is accepted

Behaviour:
- Reset (RESET = 0, async): state IDLE, SCL = 1, SdaDriveLow = 0, DataIn = 0, Load = Shift = ShiftCLK = 0, Busy = Done = AckError = 0, all counters 0. Reset mid-transaction aborts immediately and releases the bus; no STOP is generated.
- Quarter timer counts 0..CLK_DIV-1 and emits qtick on its last count. A 2-bit phase counter Q0..Q3 advances on each qtick. Both counters are held at 0 in IDLE.
- Each bit period is Q0..Q3. SCL = 0 in Q0/Q1 and 1 in Q2/Q3, except in START, which holds SCL = 1 throughout.
- IDLE: on Start = 1:
  - capture inputs;
  - DataIn = {SlaveAddr, 1'b0};
  - Load pulses in the same cycle;
  - Busy = 1 next cycle;
  - clear AckError;
  - go to START.
- START: Q0-Q1 SdaDriveLow = 0; Q2-Q3 SdaDriveLow = 1 (SDA falls while SCL is high). After the Q3 qtick, go to ADDR with bitcnt = 7.
- ADDR / DATA: SdaDriveLow = ~ShiftOut for the whole bit. On the Q3 qtick, Shift/ShiftCLK pulse for one cycle and bitcnt decrements. When bitcnt = 0, ADDR goes to ACK1 and DATA goes to ACK2.
- ACK1 / ACK2: SdaDriveLow = 0; SdaIn is sampled on the Q3 qtick.
  - SdaIn = 1: set AckError and go to STOP.
  - ACK1 with SdaIn = 0: DataIn = captured WriteData, Load pulses on the same qtick, bitcnt = 7, go to DATA.
  - ACK2 with SdaIn = 0: go to STOP.
- STOP: Q0-Q2 SdaDriveLow = 1; Q3 SdaDriveLow = 0 (SDA rises while SCL is high). On the Q3 qtick, go to DONE.
- DONE: Done = 1 for one cycle, Busy = 0 next cycle, return to IDLE, SCL = 1.
- Load and Shift never assert in the same cycle.
- Start while Busy = 1 is ignored. Start held high is re-accepted the cycle after DONE.
- Latency (Start accepted at edge k): Done is high in cycle k+1+80*CLK_DIV for a full write (20 bit periods). On address NACK it is k+1+44*CLK_DIV (11 bit periods).

Test Plan:
1. CLK_DIV=2, RESET low for 2 cycles, then high -> SCL=1, SdaDriveLow=0, Busy=0, Done=0, AckError=0.
2. Start pulse, SlaveAddr=7'h50, WriteData=8'hA5, SdaIn=0 on both ACKs -> Load with DataIn=8'hA0, then later DataIn=8'hA5. Decoded SDA bits are 1010_0000 and 1010_0101. Exactly 16 Shift pulses. Done in cycle k+161, AckError=0.
3. Same as 2, but SdaIn=1 during ACK1 -> AckError=1, no second Load, STOP issued, Done in cycle k+89.
4. SdaIn=1 only during ACK2 -> AckError=1, Done in cycle k+161. A subsequent accepted Start clears AckError.
5. Start pulsed again at cycle k+40 while Busy -> ignored; captured address and data unchanged, exactly one Done.
6. RESET asserted mid-DATA at bit 3 -> same cycle SCL=1, SdaDriveLow=0, Busy=0; after release, a new Start completes normally.
